lsu_req_queue: RTL and testbench

Parametrised execute-stage memory-request unit that sits between the EX stage and the data-cache request port. It checks alignment, builds byte strobes and lane-replicated store data for any power-of-two data width, and buffers up to DEPTH formatted requests. The EX stage therefore no longer stalls on a single-cycle `data_addr_ok` handshake. Misaligned requests are not enqueued; they produce a registered ALE report instead.

---
 rtl/lsu_req_queue_if.sv | 49 ++++
 rtl/lsu_req_queue.sv | 164 ++++++++++++++++
 tb/tb_lsu_req_queue.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_req_queue_if.sv
// Request-side bundle between the EX stage, the request queue and the data-cache port.
// The master modport is the EX/cache side; the slave modport is the queue itself.
interface lsu_req_queue_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned TAG_W  = 5
);
    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    // EX-side request
    logic              in_valid;
    logic              in_ready;
    logic              in_op;
    logic [1:0]        in_size;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_wdata;
    logic [TAG_W-1:0]  in_tag;
    logic              flush;

    // Cache-side request (queue head)
    logic              req_valid;
    logic              req_op;
    logic [2:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [NB-1:0]     req_wstrb;
    logic [DATA_W-1:0] req_wdata;
    logic [TAG_W-1:0]  req_tag;
    logic              req_addr_ok;

    // Alignment exception report and occupancy
    logic              ale_valid;
    logic [ADDR_W-1:0] ale_addr;
    logic [TAG_W-1:0]  ale_tag;
    logic [CNT_W-1:0]  count;

    modport master (
        output in_valid, in_op, in_size, in_addr, in_wdata, in_tag, flush, req_addr_ok,
        input  in_ready, req_valid, req_op, req_size, req_addr, req_wstrb, req_wdata, req_tag,
        input  ale_valid, ale_addr, ale_tag, count
    );

    modport slave (
        input  in_valid, in_op, in_size, in_addr, in_wdata, in_tag, flush, req_addr_ok,
        output in_ready, req_valid, req_op, req_size, req_addr, req_wstrb, req_wdata, req_tag,
        output ale_valid, ale_addr, ale_tag, count
    );
endinterface

// File: rtl/lsu_req_queue.sv
// Execute-stage memory-request queue: alignment check, byte-strobe and lane-replicated
// store-data formatting, and a DEPTH-entry FIFO in front of the data-cache request port.
module lsu_req_queue #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned TAG_W  = 5
) (
    input logic            clk,
    input logic            reset,
    lsu_req_queue_if.slave bus
);
    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(NB);
    localparam int unsigned IDX_W = $clog2(DATA_W);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic              op;
        logic [1:0]        size;
        logic [ADDR_W-1:0] addr;
        logic [NB-1:0]     wstrb;
        logic [DATA_W-1:0] wdata;
        logic [TAG_W-1:0]  tag;
    } entry_t;

    entry_t            mem [DEPTH];
    entry_t            new_entry;
    entry_t            head;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ale_valid_q;
    logic [ADDR_W-1:0] ale_addr_q;
    logic [TAG_W-1:0]  ale_tag_q;

    logic [OFF_W-1:0]  off;
    logic              misaligned;
    logic [NB-1:0]     base;
    logic [IDX_W-1:0]  lane_mask;
    logic              in_ready;
    logic              accept;
    logic              push;
    logic              pop;
    logic              req_valid;

    // Alignment check, byte strobe and lane replication of the incoming request
    always_comb begin
        off        = bus.in_addr[OFF_W-1:0];
        misaligned = 1'b0;
        base       = '0;
        lane_mask  = '0;
        case (bus.in_size)
            2'd0: begin
                base      = NB'(8'h01);
                lane_mask = IDX_W'(7);
            end
            2'd1: begin
                misaligned = off[0];
                base       = NB'(8'h03);
                lane_mask  = IDX_W'(15);
            end
            2'd2: begin
                misaligned = (off[1:0] != 2'b00);
                base       = NB'(8'h0F);
                lane_mask  = IDX_W'(31);
            end
            default: begin
                // dword only exists on a 64-bit path
                misaligned = (DATA_W == 32) || (off != '0);
                base       = NB'(8'hFF);
                lane_mask  = IDX_W'(63);
            end
        endcase
        new_entry.op    = bus.in_op;
        new_entry.size  = bus.in_size;
        new_entry.addr  = bus.in_addr;
        new_entry.wstrb = base << off;
        new_entry.tag   = bus.in_tag;
        new_entry.wdata = '0;
        for (int i = 0; i < DATA_W; i++) begin
            new_entry.wdata[i] = bus.in_op & bus.in_wdata[IDX_W'(i) & lane_mask];
        end
    end

    // Handshake decode; in_ready looks only at registered count and flush
    always_comb begin
        in_ready  = (count_q != CNT_W'(DEPTH)) && !bus.flush;
        accept    = bus.in_valid && in_ready;
        push      = accept && !misaligned;
        req_valid = (count_q != '0);
        pop       = req_valid && bus.req_addr_ok;
    end

    // Pointer and occupancy next state; flush wins over push and pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop) count_d = count_q + 1'b1;
            if (pop && !push) count_d = count_q - 1'b1;
        end
    end

    // Queue control registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; stale contents are harmless because outputs are gated by req_valid
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= new_entry;
    end

    // Registered alignment-exception report, one pulse per misaligned accept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ale_valid_q <= 1'b0;
            ale_addr_q  <= '0;
            ale_tag_q   <= '0;
        end else begin
            ale_valid_q <= accept && misaligned;
            if (accept && misaligned) begin
                ale_addr_q <= bus.in_addr;
                ale_tag_q  <= bus.in_tag;
            end
        end
    end

    // Head presentation, zeroed while the queue is empty
    always_comb begin
        head = '0;
        if (req_valid) head = mem[rd_ptr_q];
    end

    assign bus.in_ready  = in_ready;
    assign bus.req_valid = req_valid;
    assign bus.req_op    = head.op;
    assign bus.req_size  = {1'b0, head.size};
    assign bus.req_addr  = head.addr;
    assign bus.req_wstrb = head.wstrb;
    assign bus.req_wdata = head.wdata;
    assign bus.req_tag   = head.tag;
    assign bus.ale_valid = ale_valid_q;
    assign bus.ale_addr  = ale_addr_q;
    assign bus.ale_tag   = ale_tag_q;
    assign bus.count     = count_q;
endmodule

// File: tb/tb_lsu_req_queue.sv
// Self-checking bench for lsu_req_queue: a 64-bit instance driven from a vector table and
// corner-case sequences with a scoreboard on the cache side, plus a 32-bit instance.
module tb_lsu_req_queue;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lsu_req_queue_if #(.DATA_W(64), .ADDR_W(32), .DEPTH(2), .TAG_W(5)) b64 ();
    lsu_req_queue_if #(.DATA_W(32), .ADDR_W(32), .DEPTH(2), .TAG_W(5)) b32 ();

    lsu_req_queue #(.DATA_W(64), .ADDR_W(32), .DEPTH(2), .TAG_W(5)) u_dut64 (
        .clk   (clk),
        .reset (reset),
        .bus   (b64.slave)
    );
    lsu_req_queue #(.DATA_W(32), .ADDR_W(32), .DEPTH(2), .TAG_W(5)) u_dut32 (
        .clk   (clk),
        .reset (reset),
        .bus   (b32.slave)
    );

    typedef struct {
        logic        op;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [7:0]  wstrb;
        logic [63:0] wdata;
        logic [4:0]  tag;
    } req_t;

    typedef struct {
        logic [31:0] addr;
        logic [4:0]  tag;
    } ale_t;

    typedef struct {
        logic        op;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [63:0] src;
        logic [4:0]  tag;
        logic        mis;
        logic [7:0]  wstrb;
        logic [63:0] wdata;
    } vec_t;

    req_t exp_q[$];
    ale_t ale_q[$];
    vec_t vecs[10];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Cache-side scoreboard for the 64-bit instance, sampled at the falling edge
    task automatic monitor();
        req_t e;
        ale_t a;
        if (b64.req_valid && b64.req_addr_ok) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_req actual_tag=%0d required=none", b64.req_tag);
            end else begin
                e = exp_q.pop_front();
                chk("req_op", 64'(b64.req_op), 64'(e.op));
                chk("req_size", 64'(b64.req_size), 64'(e.size));
                chk("req_addr", 64'(b64.req_addr), 64'(e.addr));
                chk("req_wstrb", 64'(b64.req_wstrb), 64'(e.wstrb));
                chk("req_wdata", b64.req_wdata, e.wdata);
                chk("req_tag", 64'(b64.req_tag), 64'(e.tag));
            end
        end
        if (b64.ale_valid) begin
            if (ale_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ale actual_tag=%0d required=none", b64.ale_tag);
            end else begin
                a = ale_q.pop_front();
                chk("ale_addr", 64'(b64.ale_addr), 64'(a.addr));
                chk("ale_tag", 64'(b64.ale_tag), 64'(a.tag));
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic drive64(input logic op, input logic [1:0] size, input logic [31:0] addr,
                           input logic [63:0] src, input logic [4:0] tag);
        b64.in_valid = 1'b1;
        b64.in_op    = op;
        b64.in_size  = size;
        b64.in_addr  = addr;
        b64.in_wdata = src;
        b64.in_tag   = tag;
    endtask

    task automatic expect_word_load(input logic [31:0] addr, input logic [4:0] tag);
        req_t e;
        e.op    = 1'b0;
        e.size  = 3'd2;
        e.addr  = addr;
        e.wstrb = 8'h0F;
        e.wdata = '0;
        e.tag   = tag;
        exp_q.push_back(e);
    endtask

    initial begin
        req_t e;
        ale_t a;

        vecs[0] = '{op: 1'b1, size: 2'd0, addr: 32'h1003, src: 64'hA5, tag: 5'd1, mis: 1'b0,
                    wstrb: 8'h08, wdata: 64'hA5A5_A5A5_A5A5_A5A5};
        vecs[1] = '{op: 1'b1, size: 2'd1, addr: 32'h2006, src: 64'h1234, tag: 5'd2, mis: 1'b0,
                    wstrb: 8'hC0, wdata: 64'h1234_1234_1234_1234};
        vecs[2] = '{op: 1'b1, size: 2'd3, addr: 32'h2008, src: 64'h1122_3344_5566_7788,
                    tag: 5'd3, mis: 1'b0, wstrb: 8'hFF, wdata: 64'h1122_3344_5566_7788};
        vecs[3] = '{op: 1'b0, size: 2'd2, addr: 32'h3004, src: 64'hFFFF_FFFF, tag: 5'd4,
                    mis: 1'b0, wstrb: 8'hF0, wdata: 64'h0};
        vecs[4] = '{op: 1'b0, size: 2'd2, addr: 32'h3002, src: 64'h0, tag: 5'd7, mis: 1'b1,
                    wstrb: 8'h00, wdata: 64'h0};
        vecs[5] = '{op: 1'b1, size: 2'd2, addr: 32'h4000, src: 64'hDEAD_BEEF_CAFE_F00D,
                    tag: 5'd8, mis: 1'b0, wstrb: 8'h0F, wdata: 64'hCAFE_F00D_CAFE_F00D};
        vecs[6] = '{op: 1'b0, size: 2'd1, addr: 32'h5001, src: 64'h0, tag: 5'd9, mis: 1'b1,
                    wstrb: 8'h00, wdata: 64'h0};
        vecs[7] = '{op: 1'b0, size: 2'd3, addr: 32'h6004, src: 64'h0, tag: 5'd10, mis: 1'b1,
                    wstrb: 8'h00, wdata: 64'h0};
        vecs[8] = '{op: 1'b0, size: 2'd0, addr: 32'h7007, src: 64'h0, tag: 5'd11, mis: 1'b0,
                    wstrb: 8'h80, wdata: 64'h0};
        vecs[9] = '{op: 1'b1, size: 2'd1, addr: 32'h8002, src: 64'hFFFF_BEEF, tag: 5'd12,
                    mis: 1'b0, wstrb: 8'h0C, wdata: 64'hBEEF_BEEF_BEEF_BEEF};

        reset = 1'b1;
        b64.in_valid = 0; b64.in_op = 0; b64.in_size = 0; b64.in_addr = 0;
        b64.in_wdata = 0; b64.in_tag = 0; b64.flush = 0; b64.req_addr_ok = 0;
        b32.in_valid = 0; b32.in_op = 0; b32.in_size = 0; b32.in_addr = 0;
        b32.in_wdata = 0; b32.in_tag = 0; b32.flush = 0; b32.req_addr_ok = 0;

        // Reset values
        #12;
        chk("rst_in_ready", 64'(b64.in_ready), 64'd1);
        chk("rst_req_valid", 64'(b64.req_valid), 64'd0);
        chk("rst_req_op", 64'(b64.req_op), 64'd0);
        chk("rst_req_size", 64'(b64.req_size), 64'd0);
        chk("rst_req_addr", 64'(b64.req_addr), 64'd0);
        chk("rst_req_wstrb", 64'(b64.req_wstrb), 64'd0);
        chk("rst_req_wdata", b64.req_wdata, 64'd0);
        chk("rst_req_tag", 64'(b64.req_tag), 64'd0);
        chk("rst_ale_valid", 64'(b64.ale_valid), 64'd0);
        chk("rst_ale_addr", 64'(b64.ale_addr), 64'd0);
        chk("rst_ale_tag", 64'(b64.ale_tag), 64'd0);
        chk("rst_count", 64'(b64.count), 64'd0);
        chk("rst_in_ready32", 64'(b32.in_ready), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Vector table at full throughput with the cache always accepting
        b64.req_addr_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive64(vecs[i].op, vecs[i].size, vecs[i].addr, vecs[i].src, vecs[i].tag);
            chk("vec_in_ready", 64'(b64.in_ready), 64'd1);
            if (vecs[i].mis) begin
                a.addr = vecs[i].addr;
                a.tag  = vecs[i].tag;
                ale_q.push_back(a);
            end else begin
                e.op    = vecs[i].op;
                e.size  = {1'b0, vecs[i].size};
                e.addr  = vecs[i].addr;
                e.wstrb = vecs[i].wstrb;
                e.wdata = vecs[i].wdata;
                e.tag   = vecs[i].tag;
                exp_q.push_back(e);
            end
            tick();
        end
        b64.in_valid = 1'b0;
        repeat (3) tick();
        chk("vec_req_left", 64'(exp_q.size()), 64'd0);
        chk("vec_ale_left", 64'(ale_q.size()), 64'd0);
        chk("vec_count", 64'(b64.count), 64'd0);

        // Fill and drain, repeated so both pointers wrap several times
        b64.req_addr_ok = 1'b0;
        for (int rep = 0; rep < 5; rep++) begin
            for (int k = 0; k < 3; k++) begin
                drive64(1'b0, 2'd2, 32'h100 + 32'(rep * 64 + k * 8), 64'h0, 5'(rep * 3 + k));
                chk("fill_in_ready", 64'(b64.in_ready), (k < 2) ? 64'd1 : 64'd0);
                if (k < 2) expect_word_load(32'h100 + 32'(rep * 64 + k * 8), 5'(rep * 3 + k));
                tick();
            end
            b64.in_valid = 1'b0;
            chk("fill_count", 64'(b64.count), 64'd2);
            chk("hold_tag", 64'(b64.req_tag), 64'(rep * 3));
            tick();
            chk("hold_addr", 64'(b64.req_addr), 64'(32'h100 + 32'(rep * 64)));
            b64.req_addr_ok = 1'b1;
            tick();
            tick();
            b64.req_addr_ok = 1'b0;
            chk("drain_count", 64'(b64.count), 64'd0);
            chk("drain_req_valid", 64'(b64.req_valid), 64'd0);
        end

        // Flush with a full queue: head issues on the flush edge, the rest is dropped
        drive64(1'b0, 2'd2, 32'h900, 64'h0, 5'd20);
        expect_word_load(32'h900, 5'd20);
        tick();
        drive64(1'b0, 2'd2, 32'h908, 64'h0, 5'd21);
        tick();
        drive64(1'b0, 2'd2, 32'h3002, 64'h0, 5'd22);
        b64.flush = 1'b1;
        b64.req_addr_ok = 1'b1;
        chk("flush_in_ready", 64'(b64.in_ready), 64'd0);
        tick();
        b64.flush = 1'b0;
        b64.in_valid = 1'b0;
        b64.req_addr_ok = 1'b0;
        chk("flush_count", 64'(b64.count), 64'd0);
        chk("flush_req_valid", 64'(b64.req_valid), 64'd0);
        chk("flush_ale", 64'(b64.ale_valid), 64'd0);
        chk("flush_issued", 64'(exp_q.size()), 64'd0);

        // Flush on an empty queue suppresses a misaligned report
        drive64(1'b0, 2'd1, 32'h5003, 64'h0, 5'd23);
        b64.flush = 1'b1;
        tick();
        b64.flush = 1'b0;
        b64.in_valid = 1'b0;
        chk("flush_empty_ale", 64'(b64.ale_valid), 64'd0);

        // Asynchronous reset with one entry held
        drive64(1'b0, 2'd2, 32'h400, 64'h0, 5'd25);
        tick();
        b64.in_valid = 1'b0;
        chk("pre_rst_count", 64'(b64.count), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_req_valid", 64'(b64.req_valid), 64'd0);
        chk("async_rst_count", 64'(b64.count), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_count", 64'(b64.count), 64'd0);

        // 32-bit path: byte store replication
        b32.in_valid = 1'b1; b32.in_op = 1'b1; b32.in_size = 2'd0;
        b32.in_addr = 32'h1003; b32.in_wdata = 32'hA5; b32.in_tag = 5'd3;
        tick();
        b32.in_valid = 1'b0;
        chk("b32_req_valid", 64'(b32.req_valid), 64'd1);
        chk("b32_wstrb", 64'(b32.req_wstrb), 64'h8);
        chk("b32_wdata", 64'(b32.req_wdata), 64'hA5A5_A5A5);
        chk("b32_size", 64'(b32.req_size), 64'd0);
        chk("b32_addr", 64'(b32.req_addr), 64'h1003);
        chk("b32_tag", 64'(b32.req_tag), 64'd3);
        b32.req_addr_ok = 1'b1;
        tick();
        b32.req_addr_ok = 1'b0;
        chk("b32_count", 64'(b32.count), 64'd0);

        // 32-bit path: dword size is illegal even when aligned
        b32.in_valid = 1'b1; b32.in_op = 1'b0; b32.in_size = 2'd3;
        b32.in_addr = 32'h0; b32.in_tag = 5'd5;
        tick();
        b32.in_valid = 1'b0;
        chk("b32_ale_valid", 64'(b32.ale_valid), 64'd1);
        chk("b32_ale_addr", 64'(b32.ale_addr), 64'h0);
        chk("b32_ale_tag", 64'(b32.ale_tag), 64'd5);
        chk("b32_ale_count", 64'(b32.count), 64'd0);
        tick();
        chk("b32_ale_pulse", 64'(b32.ale_valid), 64'd0);

        chk("sb_req_left", 64'(exp_q.size()), 64'd0);
        chk("sb_ale_left", 64'(ale_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
